// File: rtl/big_core_fpga_io_if.sv
// ---------------------------------------------------------------------------
// big_core_fpga_io_if
//
// CR-memory side of the board I/O block.
//
// Contents:
//   fpga_out  t_fpga_out  SEG7_0..SEG7_5 (8 bits each) and LED (10 bits),
//                         produced by the CR memory
//   btn_clr   1           clear pulse for sticky button flags
//   Button_0  1           debounced key 0, active-high
//   Button_1  1           debounced key 1, active-high
//   Switch    10          debounced slide switches
//
// Modports:
//   master  the CR memory: drives fpga_out and btn_clr, reads the inputs
//   slave   the I/O block: reads fpga_out and btn_clr, drives the inputs
// ---------------------------------------------------------------------------
interface big_core_fpga_io_if;

    typedef struct packed {
        logic [7:0] SEG7_0;
        logic [7:0] SEG7_1;
        logic [7:0] SEG7_2;
        logic [7:0] SEG7_3;
        logic [7:0] SEG7_4;
        logic [7:0] SEG7_5;
        logic [9:0] LED;
    } t_fpga_out;

    t_fpga_out  fpga_out;
    logic       btn_clr;
    logic       Button_0;
    logic       Button_1;
    logic [9:0] Switch;

    modport master (
        output fpga_out,
        output btn_clr,
        input  Button_0,
        input  Button_1,
        input  Switch
    );

    modport slave (
        input  fpga_out,
        input  btn_clr,
        output Button_0,
        output Button_1,
        output Switch
    );

endinterface

// File: rtl/big_core_fpga_io.sv
// ---------------------------------------------------------------------------
// big_core_fpga_io
//
// Board-side end of the control-register interface.
//
// Input path : raw keys and slide switches are (optionally) inverted,
//              passed through 2-flop synchronizers and debounced bit by bit,
//              then presented to the CR memory as Button_0/Button_1/Switch.
// Output path: the fpga_out structure from the CR memory is registered onto
//              the seven-segment and LED pins with one cycle of latency.
//
// Ports:
//   Clk      in   core clock
//   Rst_n    in   asynchronous active-low reset
//   KEY_0    in   raw board key 0 (asynchronous to Clk)
//   KEY_1    in   raw board key 1 (asynchronous to Clk)
//   SW       in   raw slide switches [9:0] (asynchronous to Clk)
//   cr       if   CR-memory side (slave modport): fpga_out, btn_clr in;
//                 Button_0, Button_1, Switch out
//   HEX0..5  out  seven-segment pins, segment[6:0] plus dp[7]
//   LEDR     out  LED pins [9:0]
//
// Parameters:
//   DEB_CYC      cycles a synchronized input must differ from its stable
//                value before the stable value follows it (>= 1)
//   KEY_ACT_LOW  1: raw keys are active-low and are inverted on entry
//   SEG_ACT_LOW  1: HEX pins are the bitwise inverse of the SEG7 fields
//
// Optional feature (compile-time macro CR_IO_BTN_STICKY_EN):
//   Button_0/Button_1 become sticky press flags, set on a 0->1 edge of the
//   debounced key and cleared the cycle after btn_clr; set wins over clear.
//   Without the macro the buttons follow the debounced level directly.
// ---------------------------------------------------------------------------
module big_core_fpga_io #(
    parameter int DEB_CYC     = 500000,
    parameter int KEY_ACT_LOW = 1,
    parameter int SEG_ACT_LOW = 1
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic                    KEY_0,
    input  logic                    KEY_1,
    input  logic [9:0]              SW,
    big_core_fpga_io_if.slave       cr,
    output logic [7:0]              HEX0,
    output logic [7:0]              HEX1,
    output logic [7:0]              HEX2,
    output logic [7:0]              HEX3,
    output logic [7:0]              HEX4,
    output logic [7:0]              HEX5,
    output logic [9:0]              LEDR
);

    // Counter width is derived from DEB_CYC.
    localparam int                CNT_W     = $clog2(DEB_CYC + 1);
    localparam int                N_IN      = 12;
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEB_CYC - 1);
    localparam logic [7:0]        HEX_BLANK = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;

    // -----------------------------------------------------------------------
    // Input conditioning
    // Bit map of the 12 conditioned inputs: [0] key 0, [1] key 1,
    // [11:2] switches 9..0.
    // -----------------------------------------------------------------------
    logic [1:0]       key_w;
    logic [N_IN-1:0]  raw_w;

    assign key_w = (KEY_ACT_LOW != 0) ? ~{KEY_1, KEY_0} : {KEY_1, KEY_0};
    assign raw_w = {SW, key_w};

    logic [N_IN-1:0]  sync1_q;
    logic [N_IN-1:0]  sync2_q;
    logic [N_IN-1:0]  stable_q;
    logic [N_IN-1:0]  stable_d;
    logic [CNT_W-1:0] cnt_q [N_IN];
    logic [CNT_W-1:0] cnt_d [N_IN];

    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_deb
            logic differ_w;
            logic done_w;

            // The count only advances while the synchronized level disagrees
            // with the stable one; any agreement (including a glitch that
            // returns) restarts it from zero.
            assign differ_w     = sync2_q[gi] ^ stable_q[gi];
            assign done_w       = differ_w && (cnt_q[gi] == CNT_MAX);
            assign stable_d[gi] = done_w ? sync2_q[gi] : stable_q[gi];
            assign cnt_d[gi]    = (!differ_w || done_w) ? '0
                                                        : cnt_q[gi] + CNT_W'(1);

            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    sync1_q[gi]  <= 1'b0;
                    sync2_q[gi]  <= 1'b0;
                    stable_q[gi] <= 1'b0;
                    cnt_q[gi]    <= '0;
                end else begin
                    sync1_q[gi]  <= raw_w[gi];
                    sync2_q[gi]  <= sync1_q[gi];
                    stable_q[gi] <= stable_d[gi];
                    cnt_q[gi]    <= cnt_d[gi];
                end
            end
        end
    endgenerate

    assign cr.Switch = stable_q[11:2];

    // -----------------------------------------------------------------------
    // Buttons
    // -----------------------------------------------------------------------
`ifdef CR_IO_BTN_STICKY_EN
    logic [1:0] sticky_q;
    logic [1:0] sticky_d;
    logic [1:0] rise_w;

    // Rise is taken from the next-state so the flag sets on the same edge
    // that the debounced level goes high.
    assign rise_w   = stable_d[1:0] & ~stable_q[1:0];
    assign sticky_d = rise_w | (sticky_q & ~{2{cr.btn_clr}});

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sticky_q <= 2'b00;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign cr.Button_0 = sticky_q[0];
    assign cr.Button_1 = sticky_q[1];
`else
    logic unused_btn_clr;

    assign unused_btn_clr = cr.btn_clr;
    assign cr.Button_0    = stable_q[0];
    assign cr.Button_1    = stable_q[1];
`endif

    // -----------------------------------------------------------------------
    // Output path: one register stage, polarity adapted for the display.
    // -----------------------------------------------------------------------
    logic [7:0] seg_w [6];
    logic [7:0] hex_q [6];
    logic [7:0] hex_d [6];
    logic [9:0] led_q;

    assign seg_w[0] = cr.fpga_out.SEG7_0;
    assign seg_w[1] = cr.fpga_out.SEG7_1;
    assign seg_w[2] = cr.fpga_out.SEG7_2;
    assign seg_w[3] = cr.fpga_out.SEG7_3;
    assign seg_w[4] = cr.fpga_out.SEG7_4;
    assign seg_w[5] = cr.fpga_out.SEG7_5;

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_hex
            assign hex_d[gi] = (SEG_ACT_LOW != 0) ? ~seg_w[gi] : seg_w[gi];

            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    hex_q[gi] <= HEX_BLANK;
                end else begin
                    hex_q[gi] <= hex_d[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            led_q <= '0;
        end else begin
            led_q <= cr.fpga_out.LED;
        end
    end

    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign HEX4 = hex_q[4];
    assign HEX5 = hex_q[5];
    assign LEDR = led_q;

endmodule

// File: tb/tb_big_core_fpga_io.sv
// ---------------------------------------------------------------------------
// tb_big_core_fpga_io
//
// Directed self-checking bench for big_core_fpga_io with DEB_CYC = 4.
// A clean input change appears on the debounced output on the 6th rising
// edge after the pin change (2 synchronizer edges + 4 counting edges).
// ---------------------------------------------------------------------------
module tb_big_core_fpga_io;

    logic       Clk;
    logic       Rst_n;
    logic       KEY_0;
    logic       KEY_1;
    logic [9:0] SW;
    logic [7:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [9:0] LEDR;

    int n_tests;
    int n_fail;

    big_core_fpga_io_if cr_if ();

    big_core_fpga_io #(
        .DEB_CYC     (4),
        .KEY_ACT_LOW (1),
        .SEG_ACT_LOW (1)
    ) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .KEY_0 (KEY_0),
        .KEY_1 (KEY_1),
        .SW    (SW),
        .cr    (cr_if),
        .HEX0  (HEX0),
        .HEX1  (HEX1),
        .HEX2  (HEX2),
        .HEX3  (HEX3),
        .HEX4  (HEX4),
        .HEX5  (HEX5),
        .LEDR  (LEDR)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance n rising edges; return 1 time unit after the last edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic test_reset();
        Rst_n  = 1'b1;
        SW     = 10'h3FF;
        KEY_0  = 1'b0;
        KEY_1  = 1'b1;
        cr_if.btn_clr  = 1'b0;
        cr_if.fpga_out = '1;
        #2;
        Rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            n_tests++;
            if (cr_if.Switch !== 10'h000 || cr_if.Button_0 !== 1'b0 || LEDR !== 10'h000) begin
                n_fail++;
                $display("FAIL reset_io cyc%0d: Switch=%h Button_0=%b LEDR=%h, want 000/0/000",
                         k, cr_if.Switch, cr_if.Button_0, LEDR);
            end
            n_tests++;
            if ({HEX0, HEX1, HEX2, HEX3, HEX4, HEX5} !== {6{8'hFF}}) begin
                n_fail++;
                $display("FAIL reset_hex cyc%0d: HEX0..5=%h %h %h %h %h %h, want all FF",
                         k, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5);
            end
        end
        SW    = 10'h000;
        KEY_0 = 1'b1;
        cr_if.fpga_out = '0;
        Rst_n = 1'b1;
        tick(8);
        n_tests++;
        if (cr_if.Switch !== 10'h000 || cr_if.Button_0 !== 1'b0 || cr_if.Button_1 !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: Switch=%h B0=%b B1=%b, want 000/0/0",
                     cr_if.Switch, cr_if.Button_0, cr_if.Button_1);
        end
        $display("[TB] reset sequence done");
    endtask

    task automatic test_switch();
        logic [9:0] exp_sw;
        SW = 10'h008;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            exp_sw = (k == 6) ? 10'h008 : 10'h000;
            n_tests++;
            if (cr_if.Switch !== exp_sw) begin
                n_fail++;
                $display("FAIL switch_latency edge%0d: Switch=%h, want %h", k, cr_if.Switch, exp_sw);
            end
        end
        tick(3);
        n_tests++;
        if (cr_if.Switch !== 10'h008) begin
            n_fail++;
            $display("FAIL switch_hold: Switch=%h, want 008", cr_if.Switch);
        end
        $display("[TB] SW[3] debounce done");
    endtask

    // Two back-to-back 3-cycle glitches: the second only stays filtered if
    // the counter really restarted from zero after the first.
    task automatic test_glitch();
        for (int g = 0; g < 2; g++) begin
            KEY_0 = 1'b0;
            tick(3);
            KEY_0 = 1'b1;
            for (int k = 0; k < 8; k++) begin
                tick(1);
                n_tests++;
                if (cr_if.Button_0 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL glitch%0d cyc%0d: Button_0=%b, want 0", g, k, cr_if.Button_0);
                end
            end
            $display("[TB] KEY_0 glitch %0d done", g);
        end
    endtask

    task automatic test_key_press();
        logic exp_b;
        KEY_0 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            exp_b = (k == 6);
            n_tests++;
            if (cr_if.Button_0 !== exp_b) begin
                n_fail++;
                $display("FAIL press_rise edge%0d: Button_0=%b, want %b", k, cr_if.Button_0, exp_b);
            end
        end
        tick(2);
        KEY_0 = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
`ifdef CR_IO_BTN_STICKY_EN
            exp_b = 1'b1;
`else
            exp_b = (k != 6);
`endif
            n_tests++;
            if (cr_if.Button_0 !== exp_b) begin
                n_fail++;
                $display("FAIL press_release edge%0d: Button_0=%b, want %b", k, cr_if.Button_0, exp_b);
            end
        end
        $display("[TB] KEY_0 press/release done");
    endtask

    task automatic test_output();
        cr_if.fpga_out        = '0;
        cr_if.fpga_out.SEG7_2 = 8'h3F;
        cr_if.fpga_out.LED    = 10'h155;
        #1;
        n_tests++;
        if (HEX2 !== 8'hFF) begin
            n_fail++;
            $display("FAIL out_latency: HEX2=%h before edge, want FF", HEX2);
        end
        tick(1);
        n_tests++;
        if (HEX2 !== 8'hC0 || LEDR !== 10'h155 || HEX0 !== 8'hFF) begin
            n_fail++;
            $display("FAIL out_pat1: HEX2=%h LEDR=%h HEX0=%h, want C0/155/FF", HEX2, LEDR, HEX0);
        end
        cr_if.fpga_out        = '0;
        cr_if.fpga_out.SEG7_0 = 8'h81;
        cr_if.fpga_out.SEG7_3 = 8'h5A;
        cr_if.fpga_out.SEG7_5 = 8'h7E;
        cr_if.fpga_out.LED    = 10'h2AA;
        tick(1);
        n_tests++;
        if ({HEX0, HEX1, HEX2, HEX3, HEX4, HEX5} !== {8'h7E, 8'hFF, 8'hFF, 8'hA5, 8'hFF, 8'h81}
            || LEDR !== 10'h2AA) begin
            n_fail++;
            $display("FAIL out_pat2: HEX0..5=%h %h %h %h %h %h LEDR=%h, want 7E FF FF A5 FF 81 / 2AA",
                     HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, LEDR);
        end
        $display("[TB] output path done");
    endtask

    task automatic test_reset_mid_debounce();
        logic       exp_b;
        logic [9:0] exp_sw;
        KEY_1 = 1'b0;
        tick(3);
        Rst_n = 1'b0;
        #1;
        n_tests++;
        if (cr_if.Button_1 !== 1'b0 || cr_if.Switch !== 10'h000) begin
            n_fail++;
            $display("FAIL async_reset: Button_1=%b Switch=%h, want 0/000",
                     cr_if.Button_1, cr_if.Switch);
        end
        tick(1);
        Rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            exp_b  = (k == 6);
            exp_sw = (k == 6) ? 10'h008 : 10'h000;
            n_tests++;
            if (cr_if.Button_1 !== exp_b || cr_if.Switch !== exp_sw) begin
                n_fail++;
                $display("FAIL mid_reset edge%0d: Button_1=%b Switch=%h, want %b/%h",
                         k, cr_if.Button_1, cr_if.Switch, exp_b, exp_sw);
            end
        end
        KEY_1 = 1'b1;
        tick(8);
        $display("[TB] reset mid-debounce done");
    endtask

`ifdef CR_IO_BTN_STICKY_EN
    task automatic test_sticky();
        cr_if.btn_clr = 1'b1;
        tick(1);
        cr_if.btn_clr = 1'b0;
        n_tests++;
        if (cr_if.Button_0 !== 1'b0 || cr_if.Button_1 !== 1'b0) begin
            n_fail++;
            $display("FAIL sticky_clr0: B0=%b B1=%b, want 0/0", cr_if.Button_0, cr_if.Button_1);
        end
        KEY_0 = 1'b0;
        tick(6);
        n_tests++;
        if (cr_if.Button_0 !== 1'b1) begin
            n_fail++;
            $display("FAIL sticky_set: Button_0=%b, want 1", cr_if.Button_0);
        end
        KEY_0 = 1'b1;
        tick(10);
        n_tests++;
        if (cr_if.Button_0 !== 1'b1) begin
            n_fail++;
            $display("FAIL sticky_hold: Button_0=%b after release, want 1", cr_if.Button_0);
        end
        cr_if.btn_clr = 1'b1;
        tick(1);
        cr_if.btn_clr = 1'b0;
        n_tests++;
        if (cr_if.Button_0 !== 1'b0) begin
            n_fail++;
            $display("FAIL sticky_clr: Button_0=%b, want 0", cr_if.Button_0);
        end
        KEY_0 = 1'b0;
        tick(5);
        n_tests++;
        if (cr_if.Button_0 !== 1'b0) begin
            n_fail++;
            $display("FAIL sticky_early: Button_0=%b at edge 5, want 0", cr_if.Button_0);
        end
        cr_if.btn_clr = 1'b1;
        tick(1);
        cr_if.btn_clr = 1'b0;
        n_tests++;
        if (cr_if.Button_0 !== 1'b1) begin
            n_fail++;
            $display("FAIL sticky_set_wins: Button_0=%b, want 1", cr_if.Button_0);
        end
        KEY_0 = 1'b1;
        tick(3);
        n_tests++;
        if (cr_if.Button_0 !== 1'b1) begin
            n_fail++;
            $display("FAIL sticky_after_coinc: Button_0=%b, want 1", cr_if.Button_0);
        end
        $display("[TB] sticky buttons done");
    endtask
`else
    task automatic test_btn_clr_ignored();
        KEY_0 = 1'b0;
        tick(6);
        cr_if.btn_clr = 1'b1;
        tick(1);
        cr_if.btn_clr = 1'b0;
        n_tests++;
        if (cr_if.Button_0 !== 1'b1) begin
            n_fail++;
            $display("FAIL btn_clr_ignored: Button_0=%b, want 1", cr_if.Button_0);
        end
        KEY_0 = 1'b1;
        tick(8);
        n_tests++;
        if (cr_if.Button_0 !== 1'b0) begin
            n_fail++;
            $display("FAIL level_release: Button_0=%b, want 0", cr_if.Button_0);
        end
        $display("[TB] btn_clr ignored in level mode done");
    endtask
`endif

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_switch();
        test_glitch();
        test_key_press();
        test_output();
        test_reset_mid_debounce();
`ifdef CR_IO_BTN_STICKY_EN
        test_sticky();
`else
        test_btn_clr_ignored();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/big_core_fpga_io.md
Name: big_core_fpga_io

Overview:
- Board-side end of the control-register interface.
- Input path: samples raw board keys and slide switches, synchronizes and debounces them, and drives the Button_0, Button_1 and Switch inputs of the CR memory.
- Output path: registers the fpga_out structure from the CR memory onto the physical seven-segment (HEX) and LED pins, with polarity adaptation.
- Sits in the FPGA top level, between the board pins and the CR memory.

Parameters:
- DEB_CYC, 500000, number of consecutive cycles a synchronized input must differ from its stable value before the stable value updates (10 ms at 50 MHz); legal range >= 1.
- CNT_W, $clog2(DEB_CYC+1), width of each debounce counter; derived, never overridden.
- KEY_ACT_LOW, 1, when 1 the raw keys are active-low and are inverted before synchronization.
- SEG_ACT_LOW, 1, when 1 the HEX outputs are the bitwise inverse of the SEG7 fields.

Ports:
- Clk  in  1  core clock.
- Rst_n  in  1  asynchronous, active-low reset.
- KEY_0  in  1  raw board key 0; asynchronous to Clk.
- KEY_1  in  1  raw board key 1; asynchronous to Clk.
- SW  in  10  raw slide switches; asynchronous to Clk.
- btn_clr  in  1  Clk-synchronous clear pulse for sticky buttons; ignored unless CR_IO_BTN_STICKY_EN is defined.
- fpga_out  in  t_fpga_out  SEG7_0..SEG7_5 (8 bits each) and LED (10 bits) from the CR memory.
- Button_0  out  1  debounced key 0, active-high, to the CR memory.
- Button_1  out  1  debounced key 1, active-high, to the CR memory.
- Switch  out  10  debounced switches, to the CR memory.
- HEX0..HEX5  out  8 each  seven-segment pins, segment[6:0] plus dp[7].
- LEDR  out  10  LED pins.

Behaviour:
- Reset (Rst_n low, asynchronous assert, synchronous-safe release):
  - Button_0 = 0, Button_1 = 0, Switch = 0, LEDR = 0.
  - HEX0..HEX5 = 8'hFF when SEG_ACT_LOW = 1, else 8'h00 (display blank).
  - All synchronizer stages, stable values and counters clear to the inactive level.
- Input conditioning, 12 independent bits (2 keys, 10 switches):
  - Keys are inverted first when KEY_ACT_LOW = 1.
  - Each bit passes a 2-flop synchronizer, giving sync.
  - Each bit owns a CNT_W counter cnt and a stable register.
- Debounce rules, per bit:
  - sync == stable: cnt <= 0.
  - sync != stable and cnt == DEB_CYC-1: stable <= sync and cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - A glitch shorter than DEB_CYC cycles never changes stable.
  - Any return to the stable level restarts the count from 0.
- Input latency:
  - A clean level change on a pin reaches the output after 2 synchronizer cycles plus DEB_CYC counting cycles.
  - Button and Switch outputs are the stable registers directly.
  - With DEB_CYC = 1, the output updates on the first cycle after sync differs.
- Output path:
  - HEXn <= SEG_ACT_LOW ? ~fpga_out.SEG7_n : fpga_out.SEG7_n.
  - LEDR <= fpga_out.LED.
  - Exactly 1 cycle of latency, updated every cycle; no handshake.
- Simultaneous events: bits are fully independent; concurrent toggles on several bits each follow their own counter.
- Reset mid-debounce: any pending change is discarded; after release, a still-held level requires a full new debounce.

Optional Feature:
- Macro: CR_IO_BTN_STICKY_EN.
- Defined:
  - Button_0 and Button_1 become sticky press flags.
  - A flag sets on the cycle its debounced stable value rises 0->1.
  - A flag clears on the cycle after btn_clr = 1.
  - When set and clear coincide on the same cycle, set wins.
  - Switch behaviour is unchanged.
- Undefined: Button_0/1 follow the debounced level, btn_clr is unused, and no sticky flops are built.

Test Plan (bench uses DEB_CYC = 4):
- Rst_n low with SW = 10'h3FF, KEY_0 = 0 -> Switch = 0, Button_0 = 0, HEX0..5 = 8'hFF, LEDR = 0 while Rst_n is low.
- SW[3] 0->1 held -> Switch = 10'h008 exactly 6 cycles after the pin change; no earlier change.
- KEY_0 driven low for 3 cycles, then high -> Button_0 stays 0 throughout; the counter returns to 0.
- fpga_out.SEG7_2 = 8'h3F, LED = 10'h155 -> next cycle HEX2 = 8'hC0, LEDR = 10'h155.
- KEY_1 held low, Rst_n pulsed low at cycle 3 of debounce, then released -> Button_1 rises 6 cycles after release, not before.
- With CR_IO_BTN_STICKY_EN: KEY_0 press and release -> Button_0 stays 1 after release; btn_clr pulse -> 0 the next cycle; press coincident with btn_clr -> stays 1.
